// File: rtl/tcdm_bank_adapter.sv
// Per-bank TCDM target endpoint: turns valid/ready requests into fixed-latency SRAM
// accesses and returns tagged read data through a credit-protected response FIFO.

module tcdm_bank_adapter_chk (
   input logic clk_i,
   input logic rst_i,
   input logic push,
   input logic pop,
   input logic full
);

   // Credits guarantee a free slot for every returning read.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full && !pop));

endmodule

module tcdm_bank_adapter #(
   parameter int unsigned NumIn = 4,
   parameter int unsigned AddrWidth = 10,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned MemLatency = 1,
   parameter int unsigned RespDepth = 3,
   localparam int unsigned IniAddrWidth = (NumIn > 1) ? $clog2(NumIn) : 1,
   localparam int unsigned BeWidth = DataWidth / 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [IniAddrWidth-1:0] req_ini_addr_i,
   input  logic [AddrWidth-1:0]    req_addr_i,
   input  logic                    req_we_i,
   input  logic [BeWidth-1:0]      req_be_i,
   input  logic [DataWidth-1:0]    req_wdata_i,
   output logic                    resp_valid_o,
   input  logic                    resp_ready_i,
   output logic [IniAddrWidth-1:0] resp_ini_addr_o,
   output logic [DataWidth-1:0]    resp_rdata_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [AddrWidth-1:0]    mem_addr_o,
   output logic [BeWidth-1:0]      mem_be_o,
   output logic [DataWidth-1:0]    mem_wdata_o,
   input  logic [DataWidth-1:0]    mem_rdata_i
);

   localparam int unsigned PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;
   localparam int unsigned CntWidth = (RespDepth > 0) ? $clog2(RespDepth + 1) : 1;
   localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(RespDepth - 1);
   localparam logic [PtrWidth-1:0] PtrOne  = PtrWidth'(1);
   localparam logic [CntWidth-1:0] CntMax  = CntWidth'(RespDepth);
   localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

   if ((MemLatency < 1) || (MemLatency > 4)) begin : g_bad_latency
      $fatal(1, "tcdm_bank_adapter: MemLatency must be within 1..4");
   end
   if (RespDepth < 1) begin : g_bad_depth
      $fatal(1, "tcdm_bank_adapter: RespDepth must be at least 1");
   end
   if ((DataWidth % 8) != 0) begin : g_bad_width
      $fatal(1, "tcdm_bank_adapter: DataWidth must be a multiple of 8");
   end

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrLast) ? {PtrWidth{1'b0}} : p + PtrOne;
   endfunction

   logic                    accept_s, rd_accept_s, push_s, pop_s, full_s;
   logic [CntWidth-1:0]     cnt_r, cnt_nxt_s, fill_r, fill_nxt_s;
   logic                    ready_r, valid_r;
   logic [MemLatency-1:0]   vld_pipe_r;
   logic [IniAddrWidth-1:0] tag_pipe_r [MemLatency];
   logic [PtrWidth-1:0]     wptr_r, rptr_r;
   logic [IniAddrWidth-1:0] fifo_ini_r [RespDepth];
   logic [DataWidth-1:0]    fifo_data_r [RespDepth];

   assign accept_s    = req_valid_i & ready_r;
   assign rd_accept_s = accept_s & ~req_we_i;
   assign push_s      = vld_pipe_r[MemLatency-1];
   assign pop_s       = valid_r & resp_ready_i;
   assign full_s      = (fill_r == CntMax);

   assign mem_req_o   = accept_s;
   assign mem_we_o    = accept_s & req_we_i;
   assign mem_be_o    = accept_s ? req_be_i : {BeWidth{1'b0}};
   assign mem_addr_o  = req_addr_i;
   assign mem_wdata_o = req_wdata_i;

   assign req_ready_o     = ready_r;
   assign resp_valid_o    = valid_r;
   assign resp_ini_addr_o = fifo_ini_r[rptr_r];
   assign resp_rdata_o    = fifo_data_r[rptr_r];

   // Next credit count and FIFO occupancy.
   always_comb begin
      cnt_nxt_s  = cnt_r;
      fill_nxt_s = fill_r;
      case ({rd_accept_s, pop_s})
         2'b10:   cnt_nxt_s = cnt_r + CntOne;
         2'b01:   cnt_nxt_s = cnt_r - CntOne;
         default: cnt_nxt_s = cnt_r;
      endcase
      case ({push_s, pop_s})
         2'b10:   fill_nxt_s = fill_r + CntOne;
         2'b01:   fill_nxt_s = fill_r - CntOne;
         default: fill_nxt_s = fill_r;
      endcase
   end

   // Credits, handshake flags and read tag pipeline.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_r      <= {CntWidth{1'b0}};
         fill_r     <= {CntWidth{1'b0}};
         ready_r    <= 1'b1;
         valid_r    <= 1'b0;
         vld_pipe_r <= {MemLatency{1'b0}};
         for (int i = 0; i < MemLatency; i++) tag_pipe_r[i] <= {IniAddrWidth{1'b0}};
      end else begin
         cnt_r         <= cnt_nxt_s;
         fill_r        <= fill_nxt_s;
         ready_r       <= (cnt_nxt_s < CntMax);
         valid_r       <= (fill_nxt_s != {CntWidth{1'b0}});
         vld_pipe_r[0] <= rd_accept_s;
         tag_pipe_r[0] <= req_ini_addr_i;
         for (int i = 1; i < MemLatency; i++) begin
            vld_pipe_r[i] <= vld_pipe_r[i-1];
            tag_pipe_r[i] <= tag_pipe_r[i-1];
         end
      end
   end

   // Response FIFO storage; a push into the slot being popped is safe since the head is read before the edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_r <= {PtrWidth{1'b0}};
         rptr_r <= {PtrWidth{1'b0}};
         for (int i = 0; i < RespDepth; i++) begin
            fifo_ini_r[i]  <= {IniAddrWidth{1'b0}};
            fifo_data_r[i] <= {DataWidth{1'b0}};
         end
      end else begin
         if (push_s) begin
            fifo_ini_r[wptr_r]  <= tag_pipe_r[MemLatency-1];
            fifo_data_r[wptr_r] <= mem_rdata_i;
            wptr_r              <= ptr_inc(wptr_r);
         end
         if (pop_s) begin
            rptr_r <= ptr_inc(rptr_r);
         end
      end
   end

   tcdm_bank_adapter_chk u_chk (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push_s),
      .pop   (pop_s),
      .full  (full_s)
   );

endmodule

// File: tb/tb_tcdm_bank_adapter.sv
// Directed scoreboard bench for tcdm_bank_adapter (NumIn=4, 32-bit data, MemLatency=1, RespDepth=3).

module tb_tcdm_bank_adapter;

   typedef struct packed {
      logic [1:0]  ini;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req_valid_i, req_ready_o, req_we_i;
   logic [1:0]  req_ini_addr_i;
   logic [9:0]  req_addr_i;
   logic [3:0]  req_be_i;
   logic [31:0] req_wdata_i;
   logic        resp_valid_o, resp_ready_i;
   logic [1:0]  resp_ini_addr_o;
   logic [31:0] resp_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [9:0]  mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o, mem_rdata_i;

   logic [31:0] bank [0:1023];
   exp_t        exp_q [$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   tcdm_bank_adapter dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_ini_addr_i(req_ini_addr_i),
      .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_ini_addr_o(resp_ini_addr_o),
      .resp_rdata_o(resp_rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   function automatic logic [31:0] exp_data(input logic [9:0] a);
      return (a == 10'd5) ? 32'hDEADBEEF : (32'hC0DE0000 | {22'd0, a});
   endfunction

   // Bank model: one-cycle read latency, garbage when no read was issued.
   initial begin
      for (int i = 0; i < 1024; i++) bank[i] = 32'hC0DE0000 | i;
      bank[5] = 32'hDEADBEEF;
   end
   always @(posedge clk) mem_rdata_i <= (mem_req_o && !mem_we_o) ? bank[mem_addr_o] : 32'hBADBAD00;

   // Monitor: every accepted response must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst_i && resp_valid_o && resp_ready_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: got ini=%0d rdata=%h, required no response", resp_ini_addr_o, resp_rdata_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (resp_ini_addr_o !== e.ini || resp_rdata_o !== e.data) begin
               errors++;
               $display("FAIL resp_data: got ini=%0d rdata=%h, required ini=%0d rdata=%h",
                        resp_ini_addr_o, resp_rdata_o, e.ini, e.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid_i = 1'b0;
      req_we_i    = 1'b0;
      req_be_i    = 4'h0;
   endtask

   task automatic set_read(input logic [1:0] ini, input logic [9:0] a);
      req_valid_i    = 1'b1;
      req_we_i       = 1'b0;
      req_ini_addr_i = ini;
      req_addr_i     = a;
      req_be_i       = 4'h0;
      req_wdata_i    = 32'h0;
   endtask

   task automatic push_exp(input logic [1:0] ini, input logic [9:0] a);
      exp_t e;
      e.ini  = ini;
      e.data = exp_data(a);
      exp_q.push_back(e);
   endtask

   task automatic try_read(input logic [1:0] ini, input logic [9:0] a, output bit acc);
      set_read(ini, a);
      @(negedge clk);
      acc = req_ready_o;
      if (acc) push_exp(ini, a);
      step();
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int  drops, gaps, early, bad, acc_n;
      bit  acc, acc2;
      rst_i = 1'b1; resp_ready_i = 1'b1;
      req_ini_addr_i = 2'd0; req_addr_i = 10'd0; req_wdata_i = 32'h0;
      idle();
      step(); step();
      rst_i = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready_o), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
      chk("rst_resp_ini", 32'(resp_ini_addr_o), 32'd0);
      chk("rst_resp_rdata", resp_rdata_o, 32'd0);
      chk("rst_mem_req", 32'(mem_req_o), 32'd0);
      step();

      // Single read, response expected two cycles later.
      set_read(2'd2, 10'd5);
      exp_q.push_back(exp_t'({2'd2, 32'hDEADBEEF}));
      @(negedge clk);
      chk("t1_mem_req", 32'(mem_req_o), 32'd1);
      chk("t1_mem_we", 32'(mem_we_o), 32'd0);
      chk("t1_mem_addr", 32'(mem_addr_o), 32'd5);
      step(); idle();
      @(negedge clk);
      chk("t1_valid_c1", 32'(resp_valid_o), 32'd0);
      step();
      @(negedge clk);
      chk("t1_valid_c2", 32'(resp_valid_o), 32'd1);
      step();
      drain();

      // Ten back-to-back reads at full throughput.
      drops = 0; gaps = 0; early = 0;
      for (int c = 0; c < 12; c++) begin
         if (c < 10) begin
            set_read(2'(c % 4), 10'(16 + c));
            push_exp(2'(c % 4), 10'(16 + c));
         end else idle();
         @(negedge clk);
         if (c < 10 && !req_ready_o) drops++;
         if (c >= 2 && !resp_valid_o) gaps++;
         if (c < 2 && resp_valid_o) early++;
         step();
      end
      chk("b2b_ready_drops", 32'(drops), 32'd0);
      chk("b2b_resp_gaps", 32'(gaps), 32'd0);
      chk("b2b_resp_early", 32'(early), 32'd0);
      drain();

      // Backpressure: only three reads fit.
      resp_ready_i = 1'b0;
      acc_n = 0;
      for (int k = 0; k < 8; k++) begin
         try_read(2'(acc_n % 4), 10'(40 + acc_n), acc);
         if (acc) acc_n++;
      end
      chk("bp_accepted", 32'(acc_n), 32'd3);
      @(negedge clk);
      chk("bp_ready_low", 32'(req_ready_o), 32'd0);
      chk("bp_hold_valid", 32'(resp_valid_o), 32'd1);
      chk("bp_hold_data", resp_rdata_o, exp_q[0].data);
      step();
      req_valid_i = 1'b1; req_we_i = 1'b1; req_be_i = 4'hF; req_addr_i = 10'd9; req_wdata_i = 32'h55AA55AA;
      @(negedge clk);
      chk("full_wr_ready", 32'(req_ready_o), 32'd0);
      chk("full_wr_mem_req", 32'(mem_req_o), 32'd0);
      chk("full_wr_mem_we", 32'(mem_we_o), 32'd0);
      chk("full_wr_mem_be", 32'(mem_be_o), 32'd0);
      step(); idle();
      resp_ready_i = 1'b1;
      gaps = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (!resp_valid_o) gaps++;
         step();
      end
      chk("bp_release_gaps", 32'(gaps), 32'd0);
      chk("bp_release_left", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk("bp_ready_back", 32'(req_ready_o), 32'd1);
      chk("bp_empty", 32'(resp_valid_o), 32'd0);
      step();

      // Write with free credits: bus strobes, no response.
      req_valid_i = 1'b1; req_we_i = 1'b1; req_be_i = 4'b0011; req_addr_i = 10'd7;
      req_ini_addr_i = 2'd1; req_wdata_i = 32'h12345678;
      @(negedge clk);
      chk("wr_mem_req", 32'(mem_req_o), 32'd1);
      chk("wr_mem_we", 32'(mem_we_o), 32'd1);
      chk("wr_mem_be", 32'(mem_be_o), 32'h3);
      chk("wr_mem_addr", 32'(mem_addr_o), 32'd7);
      chk("wr_mem_wdata", mem_wdata_o, 32'h12345678);
      step(); idle();
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (resp_valid_o) bad++;
         step();
      end
      chk("wr_no_resp", 32'(bad), 32'd0);

      // Simultaneous accept and pop with two credits in use, across pointer wraps.
      resp_ready_i = 1'b0;
      try_read(2'd0, 10'd100, acc);
      try_read(2'd1, 10'd101, acc2);
      chk("acc_pop_prefill", 32'(acc & acc2), 32'd1);
      idle(); step();
      resp_ready_i = 1'b1;
      drops = 0; gaps = 0;
      for (int k = 0; k < 8; k++) begin
         set_read(2'(k % 4), 10'(110 + k));
         push_exp(2'(k % 4), 10'(110 + k));
         @(negedge clk);
         if (!req_ready_o) drops++;
         if (!resp_valid_o) gaps++;
         step();
      end
      chk("acc_pop_ready", 32'(drops), 32'd0);
      chk("acc_pop_valid", 32'(gaps), 32'd0);
      resp_ready_i = 1'b0;
      acc_n = 0;
      for (int k = 0; k < 4; k++) begin
         try_read(2'd2, 10'(120 + acc_n), acc);
         if (acc) acc_n++;
      end
      chk("acc_pop_credit_left", 32'(acc_n), 32'd1);
      idle();
      resp_ready_i = 1'b1;
      drain();

      // Reset with two buffered responses and one read in flight.
      resp_ready_i = 1'b0;
      try_read(2'd3, 10'd200, acc);
      try_read(2'd1, 10'd201, acc);
      try_read(2'd2, 10'd202, acc);
      rst_i = 1'b1;
      idle();
      exp_q.delete();
      step();
      rst_i = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 32'(resp_valid_o), 32'd0);
      chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
      chk("mid_rst_ini", 32'(resp_ini_addr_o), 32'd0);
      chk("mid_rst_rdata", resp_rdata_o, 32'd0);
      step();
      resp_ready_i = 1'b1;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (resp_valid_o) bad++;
         step();
      end
      chk("mid_rst_no_late", 32'(bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
